// File: rtl/fb_axi_responder.sv
// fb_axi_responder
//   AXI4 slave framebuffer memory: the responder end of the VGA DMA read
//   master, plus a CPU write path so software can fill the frame.
//   One transaction at a time. Reads stream at one beat per cycle, and writes
//   are accepted at one beat per cycle. Transfer size is always 4 bytes.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two)
//   BASE_ADDR  byte address of word 0; window = [BASE_ADDR, BASE_ADDR+DEPTH*4)
//   ID_W       AXI ID width
//
// Ports
//   aclk, areset                   clock, synchronous active-high reset
//   s_ar_* / s_r_*                 read address / read data channels
//   s_aw_* / s_w_* / s_b_*         write address / data / response channels
//   Beats outside the window return SLVERR (read data 0) or are dropped
//   (write, flagged in b_resp).

module fb_axi_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ID_W      = 4
) (
  input  logic            aclk,
  input  logic            areset,

  input  logic [ID_W-1:0] s_ar_id,
  input  logic [31:0]     s_ar_addr,
  input  logic [7:0]      s_ar_len,
  input  logic [1:0]      s_ar_burst,
  input  logic            s_ar_valid,
  output logic            s_ar_ready,

  output logic [ID_W-1:0] s_r_id,
  output logic [31:0]     s_r_data,
  output logic [1:0]      s_r_resp,
  output logic            s_r_last,
  output logic            s_r_valid,
  input  logic            s_r_ready,

  input  logic [ID_W-1:0] s_aw_id,
  input  logic [31:0]     s_aw_addr,
  input  logic [7:0]      s_aw_len,
  input  logic [1:0]      s_aw_burst,
  input  logic            s_aw_valid,
  output logic            s_aw_ready,

  input  logic [31:0]     s_w_data,
  input  logic [3:0]      s_w_strb,
  input  logic            s_w_last,
  input  logic            s_w_valid,
  output logic            s_w_ready,

  output logic [ID_W-1:0] s_b_id,
  output logic [1:0]      s_b_resp,
  output logic            s_b_valid,
  input  logic            s_b_ready
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) << 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            last_wr_q, last_wr_d;   // 1: last granted transaction was a write
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;         // address of the current beat
  logic [7:0]      len_q, len_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      beat_q, beat_d;
  logic            r_valid_q, r_valid_d;
  logic [31:0]     r_data_q, r_data_d;
  logic [1:0]      r_resp_q, r_resp_d;
  logic            r_last_q, r_last_d;
  logic            b_err_q, b_err_d;

  logic [31:0]     mem_q [DEPTH];

  logic            grant_rd, grant_wr;
  logic [31:0]     rd_look_addr, rd_off, wr_off;
  logic            rd_in_win, wr_in_win;
  logic [31:0]     rd_word;
  logic            mem_we;
  logic            last_beat;

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] burst);
    // FIXED holds the address; INCR and WRAP both advance one word.
    return (burst == 2'b00) ? a : a + 32'd4;
  endfunction

  // Ties alternate: the kind not served last wins.
  assign grant_rd = s_ar_valid & (~s_aw_valid | last_wr_q);
  assign grant_wr = s_aw_valid & (~s_ar_valid | ~last_wr_q);

  // The read lookup address is the AR address when a burst starts, otherwise
  // the following beat's address. This lets the next word load on the same
  // edge as the R handshake, so the burst has no bubbles.
  assign rd_look_addr = (state_q == ST_IDLE) ? s_ar_addr : step_addr(addr_q, burst_q);
  assign rd_off       = rd_look_addr - BASE_ADDR;
  assign rd_in_win    = {1'b0, rd_off} < WIN_BYTES;
  assign rd_word      = rd_in_win ? mem_q[rd_off[IDX_W+1:2]] : '0;

  assign wr_off       = addr_q - BASE_ADDR;
  assign wr_in_win    = {1'b0, wr_off} < WIN_BYTES;

  assign last_beat    = (beat_q == len_q);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    b_err_d   = b_err_q;
    mem_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          state_d   = ST_RD;
          last_wr_d = 1'b0;
          id_d      = s_ar_id;
          addr_d    = s_ar_addr;
          len_d     = s_ar_len;
          burst_d   = s_ar_burst;
          beat_d    = '0;
          r_valid_d = 1'b1;
          r_data_d  = rd_word;
          r_resp_d  = rd_in_win ? RESP_OKAY : RESP_SLVERR;
          r_last_d  = (s_ar_len == 8'd0);
        end else if (grant_wr) begin
          state_d   = ST_WR;
          last_wr_d = 1'b1;
          id_d      = s_aw_id;
          addr_d    = s_aw_addr;
          len_d     = s_aw_len;
          burst_d   = s_aw_burst;
          beat_d    = '0;
          b_err_d   = 1'b0;
        end
      end

      ST_RD: begin
        if (s_r_ready) begin
          if (r_last_q) begin
            state_d   = ST_IDLE;
            r_valid_d = 1'b0;
            r_data_d  = '0;
            r_resp_d  = RESP_OKAY;
            r_last_d  = 1'b0;
          end else begin
            addr_d    = rd_look_addr;
            beat_d    = beat_q + 8'd1;
            r_data_d  = rd_word;
            r_resp_d  = rd_in_win ? RESP_OKAY : RESP_SLVERR;
            r_last_d  = ((beat_q + 8'd1) == len_q);
          end
        end
      end

      ST_WR: begin
        if (s_w_valid) begin
          mem_we = wr_in_win;
          // Any dropped beat or misplaced w_last marks the burst as failed.
          if (!wr_in_win || (s_w_last != last_beat)) begin
            b_err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = ST_RESP;
          end else begin
            addr_d  = step_addr(addr_q, burst_q);
            beat_d  = beat_q + 8'd1;
          end
        end
      end

      ST_RESP: begin
        if (s_b_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
      b_err_q   <= b_err_d;
    end
  end

  // Array contents survive reset, so the array has no reset branch.
  always_ff @(posedge aclk) begin
    if (mem_we && !areset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (s_w_strb[i]) begin
          mem_q[wr_off[IDX_W+1:2]][8*i +: 8] <= s_w_data[8*i +: 8];
        end
      end
    end
  end

  assign s_ar_ready = (state_q == ST_IDLE) & grant_rd;
  assign s_aw_ready = (state_q == ST_IDLE) & grant_wr;
  assign s_w_ready  = (state_q == ST_WR);

  assign s_r_valid  = r_valid_q;
  assign s_r_data   = r_data_q;
  assign s_r_resp   = r_resp_q;
  assign s_r_last   = r_last_q;
  assign s_r_id     = r_valid_q ? id_q : '0;

  assign s_b_valid  = (state_q == ST_RESP);
  assign s_b_id     = (state_q == ST_RESP) ? id_q : '0;
  assign s_b_resp   = ((state_q == ST_RESP) && b_err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule
